// File: rtl/truth_table_checker_pkg.sv
// Shared types for the truth-table checker: sweep FSM state encoding.
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } tt_state_t;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle timer: counts 0..SETTLE_CYCLES-1 while enabled and wraps; tick flags the last settle cycle.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(SETTLE_CYCLES - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign tick = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into a combinational DUT, captures f per vector after a settle time,
// and compares the captured truth table with the expected table latched at start.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 f,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured_tt,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int unsigned NV = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    function automatic logic [N_IN:0] popcount(input logic [NV-1:0] v);
        logic [N_IN:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NV; i++) begin
            cnt = cnt + {{N_IN{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Scans from the top down so the lowest set index is the one left standing.
    function automatic logic [N_IN-1:0] first_set(input logic [NV-1:0] v);
        logic [N_IN-1:0] idx;
        idx = '0;
        for (int unsigned i = NV; i > 0; i--) begin
            if (v[i-1]) begin
                idx = N_IN'(i - 1);
            end
        end
        return idx;
    endfunction

    tt_state_t       state_q, state_d;
    logic [NV-1:0]   exp_q, exp_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [NV-1:0]   cap_q, cap_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] first_q, first_d;
    logic            timer_clr;
    logic            tick;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (state_q == ST_APPLY),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        vec_d     = vec_q;
        cap_d     = cap_q;
        pass_d    = pass_q;
        err_d     = err_q;
        first_d   = first_q;
        timer_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (start) begin
                    state_d = ST_APPLY;
                    exp_d   = exp_tt;
                    vec_d   = '0;
                    cap_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            ST_APPLY: begin
                if (tick) begin
                    cap_d[vec_q] = f;
                    if (vec_q == LAST_VEC) begin
                        // Results use cap_d so the final sample is included.
                        state_d = ST_DONE;
                        pass_d  = (cap_d == exp_q);
                        err_d   = popcount(cap_d ^ exp_q);
                        first_d = first_set(cap_d ^ exp_q);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            vec_d     = '0;
            cap_d     = '0;
            pass_d    = 1'b0;
            err_d     = '0;
            first_d   = '0;
            timer_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            vec_q   <= '0;
            cap_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            vec_q   <= vec_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign vec           = vec_q;
    assign busy          = (state_q == ST_APPLY);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign captured_tt   = cap_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with a behavioural 3-input DUT driven from vec.
module tb_truth_table_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] exp_tt;
    logic       f;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured_tt;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;

    // 0 majority, 1 xor3, 2 stuck-at-0, 3 stuck-at-1
    logic [1:0] mode;

    int n_cmp = 0;
    int n_bad = 0;

    truth_table_checker #(
        .N_IN          (3),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .exp_tt        (exp_tt),
        .f             (f),
        .vec           (vec),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .captured_tt   (captured_tt),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        f = 1'b0;
        case (mode)
            2'd0: f = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
            2'd1: f = vec[2] ^ vec[1] ^ vec[0];
            2'd2: f = 1'b0;
            2'd3: f = 1'b1;
            default: f = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Pulses start, follows the sweep cycle by cycle and returns at the negedge of the done cycle.
    task automatic run_sweep(input logic [7:0] e, output int dcyc);
        int vec_bad;
        int busy_bad;
        dcyc     = 0;
        vec_bad  = 0;
        busy_bad = 0;
        exp_tt = e;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            @(negedge clk);
            if (done) begin
                dcyc = c;
            end else begin
                if (vec !== 3'((c - 1) / 4)) vec_bad++;
                if (busy !== 1'b1) busy_bad++;
            end
        end
        chk("vec_seq", vec_bad, 0);
        chk("busy_seq", busy_bad, 0);
        chk("done_cycle", dcyc, 33);
        chk("busy_in_done", {31'd0, busy}, 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] exp;
        logic [7:0] cap;
        logic       pass;
        logic [3:0] errs;
        logic [2:0] first;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int dc;
        int d1, d2, ndone;
        logic p1, p2;
        logic [3:0] e2;

        tbl[0] = '{2'd0, 8'hE8, 8'hE8, 1'b1, 4'd0, 3'd0};
        tbl[1] = '{2'd1, 8'hE8, 8'h96, 1'b0, 4'd6, 3'd1};
        tbl[2] = '{2'd2, 8'h00, 8'h00, 1'b1, 4'd0, 3'd0};
        tbl[3] = '{2'd2, 8'h80, 8'h00, 1'b0, 4'd1, 3'd7};
        tbl[4] = '{2'd3, 8'h00, 8'hFF, 1'b0, 4'd8, 3'd0};
        tbl[5] = '{2'd1, 8'h96, 8'h96, 1'b1, 4'd0, 3'd0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = 8'hA5; mode = 2'd0;
        @(negedge clk);
        chk("reset_outputs", {17'd0, vec, busy, done, pass, captured_tt, err_count, first_err_idx}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].mode;
            run_sweep(tbl[i].exp, dc);
            chk($sformatf("t%0d_captured", i), {24'd0, captured_tt}, {24'd0, tbl[i].cap});
            chk($sformatf("t%0d_pass", i), {31'd0, pass}, {31'd0, tbl[i].pass});
            chk($sformatf("t%0d_err_count", i), {28'd0, err_count}, {28'd0, tbl[i].errs});
            chk($sformatf("t%0d_first_err", i), {29'd0, first_err_idx}, {29'd0, tbl[i].first});
            chk($sformatf("t%0d_vec_in_done", i), {29'd0, vec}, 32'd7);
        end

        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("vec_back_to_zero", {29'd0, vec}, 0);
        chk("results_held", {23'd0, pass, err_count, first_err_idx}, {23'd0, 1'b1, 4'd0, 3'd0});

        // Abort at cycle 10 of a sweep.
        mode = 2'd3; exp_tt = 8'hFF;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        dc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 10) begin
                chk("abort_pre_captured", {24'd0, captured_tt}, 32'h03);
                abort = 1'b1;
            end
            if (c == 11) begin
                abort = 1'b0;
                chk("abort_state", {20'd0, busy, vec, captured_tt}, 0);
                chk("abort_results", {24'd0, pass, err_count, first_err_idx}, 0);
            end
            if (done && dc == 0) dc = c;
        end
        chk("abort_no_done", dc, 0);
        run_sweep(8'hFF, dc);
        chk("post_abort_pass", {31'd0, pass}, 1);
        chk("post_abort_captured", {24'd0, captured_tt}, 32'hFF);

        // Asynchronous reset in cycle 15 of a sweep.
        mode = 2'd3; exp_tt = 8'h00;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 15; c++) @(negedge clk);
        chk("pre_reset_captured", {24'd0, captured_tt}, 32'h07);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {17'd0, vec, busy, done, pass, captured_tt, err_count, first_err_idx}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        mode = 2'd0;
        run_sweep(8'hE8, dc);
        chk("post_reset_pass", {31'd0, pass}, 1);

        // start held high: back-to-back sweeps, exp_tt changed mid-sweep.
        mode = 2'd0; exp_tt = 8'hE8;
        d1 = 0; d2 = 0; ndone = 0; p1 = 1'b0; p2 = 1'b1; e2 = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 10) exp_tt = 8'h00;
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = c; p1 = pass; end
                if (ndone == 2) begin d2 = c; p2 = pass; e2 = err_count; end
            end
        end
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("b2b_done_count", ndone, 2);
        chk("b2b_done1_cycle", d1, 33);
        chk("b2b_done2_cycle", d2, 67);
        chk("b2b_pass1_latched_exp", {31'd0, p1}, 1);
        chk("b2b_pass2", {31'd0, p2}, 0);
        chk("b2b_err2", {28'd0, e2}, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
